// File: rtl/fetch_redirect_unit_pkg.sv
// rtl/fetch_redirect_unit_pkg.sv - shared branch codes, reset PC and fetch state type
//
// Holds the 4-bit branch-operation codes produced by the decoder for the
// instruction in execute, the default first fetch address and the fetch
// sequencer state enumeration. Imported by the fetch unit and its branch
// resolver so both agree on encodings.

package fetch_redirect_unit_pkg;

    // First fetch address after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Branch codes as emitted by the decoder. Codes 14 and 15 are unused
    // and behave exactly like BR_NONE.
    localparam logic [3:0] BR_NONE   = 4'd0;
    localparam logic [3:0] BR_JR     = 4'd1;
    localparam logic [3:0] BR_J      = 4'd2;
    localparam logic [3:0] BR_JAL    = 4'd3;
    localparam logic [3:0] BR_BAL    = 4'd4;
    localparam logic [3:0] BR_BGEZAL = 4'd5;
    localparam logic [3:0] BR_BLTZ   = 4'd6;
    localparam logic [3:0] BR_BGEZ   = 4'd7;
    localparam logic [3:0] BR_BLTZAL = 4'd8;
    localparam logic [3:0] BR_B      = 4'd9;
    localparam logic [3:0] BR_BEQ    = 4'd10;
    localparam logic [3:0] BR_BNE    = 4'd11;
    localparam logic [3:0] BR_BLEZ   = 4'd12;
    localparam logic [3:0] BR_BGTZ   = 4'd13;

    // Fetch sequencer states.
    //   IDLE : one settling cycle after reset release
    //   REQ  : request presented to instruction memory
    //   WAIT : request in flight, waiting for imem_ready
    //   HOLD : word presented to decode, waiting for if_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Branch displacement: sign-extended 16-bit word offset scaled to bytes.
    function automatic logic [31:0] branch_disp(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_branch_resolve.sv
// rtl/fetch_redirect_unit_branch_resolve.sv - combinational branch taken/target evaluation
//
// Purely combinational: decides whether the control-flow instruction in
// execute is taken and where it goes. The fetch unit registers the result.
//
// Ports:
//   br_valid  in   1   br_* describe a resolving control-flow instruction
//   br_op     in   4   decoder branch code (BR_* in the package)
//   br_pc     in  32   PC of the branch instruction
//   br_rs     in  32   rs operand value
//   br_rt     in  32   rt operand value
//   br_imm    in  16   branch offset field (words)
//   br_tgt    in  26   jump index field
//   taken_o   out  1   branch/jump is taken this cycle
//   target_o  out 32   destination PC (meaningful when taken_o=1)

module branch_resolve
    import fetch_redirect_unit_pkg::*;
(
    input  logic        br_valid,
    input  logic [3:0]  br_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_rs,
    input  logic [31:0] br_rt,
    input  logic [15:0] br_imm,
    input  logic [25:0] br_tgt,
    output logic        taken_o,
    output logic [31:0] target_o
);

    logic [31:0] seq_pc;
    logic        rs_neg;
    logic        rs_zero;
    logic        cond;

    // Signed compares against zero reduce to the sign bit and a zero test.
    assign seq_pc  = br_pc + 32'd4;
    assign rs_neg  = br_rs[31];
    assign rs_zero = (br_rs == 32'd0);

    always_comb begin
        cond = 1'b0;
        unique case (br_op)
            BR_NONE:                             cond = 1'b0;
            BR_JR, BR_J, BR_JAL, BR_BAL, BR_B:   cond = 1'b1;
            BR_BGEZAL, BR_BGEZ:                  cond = !rs_neg;
            BR_BLTZ, BR_BLTZAL:                  cond = rs_neg;
            BR_BEQ:                              cond = (br_rs == br_rt);
            BR_BNE:                              cond = (br_rs != br_rt);
            BR_BLEZ:                             cond = rs_neg || rs_zero;
            BR_BGTZ:                             cond = !rs_neg && !rs_zero;
            default:                             cond = 1'b0;
        endcase
    end

    assign taken_o = br_valid && cond;

    always_comb begin
        target_o = seq_pc + branch_disp(br_imm);
        if (br_op == BR_JR) begin
            target_o = br_rs;
        end else if ((br_op == BR_J) || (br_op == BR_JAL)) begin
            // Region-relative jump: keep the top nibble of the sequential PC.
            target_o = {seq_pc[31:28], br_tgt, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - instruction fetch stage with branch redirect
//
// Owns the PC, issues one instruction-memory request at a time, presents the
// returned word to decode with a valid/ready handshake and applies taken
// branch/jump redirects (no delay slot: younger fetched words are flushed).
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request (one cycle, state REQ)
//   imem_addr    out 32   word-aligned fetch address (0 when not requesting)
//   imem_ready   in   1   imem_rdata valid this cycle
//   imem_rdata   in  32   fetched instruction word
//   if_valid     out  1   if_instr/if_pc valid to decode
//   if_ready     in   1   decode accepts the current word
//   if_instr     out 32   instruction word
//   if_pc        out 32   address of if_instr
//   br_*         in       resolving control-flow instruction from execute
//   redirect     out  1   one-cycle pulse: fetch redirected
//   redirect_pc  out 32   new PC while redirect=1

module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              br_valid,
    input  logic [3:0]        br_op,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [31:0]       br_rs,
    input  logic [31:0]       br_rt,
    input  logic [15:0]       br_imm,
    input  logic [25:0]       br_tgt,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              drop_q, drop_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    logic              br_taken;
    logic [31:0]       br_target;

    branch_resolve u_branch_resolve (
        .br_valid (br_valid),
        .br_op    (br_op),
        .br_pc    (br_pc),
        .br_rs    (br_rs),
        .br_rt    (br_rt),
        .br_imm   (br_imm),
        .br_tgt   (br_tgt),
        .taken_o  (br_taken),
        .target_o (br_target)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= '0;
            drop_q        <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            drop_q        <= drop_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        drop_d        = drop_q;
        redirect_d    = br_taken;
        redirect_pc_d = redirect_pc_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (imem_ready) begin
                    if (drop_q) begin
                        // Response to a request issued before a redirect.
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + ADDR_W'(4);
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A taken redirect overrides the normal sequencing in every state.
        // In HOLD a simultaneous if_ready still counts as accepted: the word
        // was consumed by decode, only the fetch path is steered elsewhere.
        if (br_taken) begin
            redirect_pc_d = br_target;
            pc_d          = br_target;
            if_valid_d    = 1'b0;
            if_instr_d    = if_instr_q;
            if_pc_d       = if_pc_q;
            unique case (state_q)
                REQ: begin
                    // The request just issued is already in flight.
                    drop_d  = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_ready) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    state_d = REQ;
                end
                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Unaligned redirect targets are kept in the PC (and reported on if_pc)
    // so the exception can be raised downstream; memory always sees a word
    // address. The address bus idles at zero outside REQ.
    assign imem_req    = (state_q == REQ);
    assign imem_addr   = imem_req ? {pc_q[ADDR_W-1:2], 2'b00} : '0;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - self-checking bench for fetch_redirect_unit

module tb_fetch_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        br_valid;
    logic [3:0]  br_op;
    logic [31:0] br_pc;
    logic [31:0] br_rs;
    logic [31:0] br_rt;
    logic [15:0] br_imm;
    logic [25:0] br_tgt;
    logic        redirect;
    logic [31:0] redirect_pc;

    int passed = 0;
    int total  = 0;

    int          mem_lat = 1;
    bit          rnd_lat = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr;
    logic [31:0] req_q[$];

    fetch_redirect_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .br_valid    (br_valid),
        .br_op       (br_op),
        .br_pc       (br_pc),
        .br_rs       (br_rs),
        .br_rt       (br_rt),
        .br_imm      (br_imm),
        .br_tgt      (br_tgt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Memory: every request is logged; the word answers after the latency.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ready = 1'b0;
            rsp_cnt    = 0;
        end else begin
            imem_ready = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt = rsp_cnt - 1;
                if (rsp_cnt == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(rsp_addr);
                end
            end
            if (imem_req === 1'b1) begin
                rsp_addr = imem_addr;
                rsp_cnt  = rnd_lat ? int'($urandom_range(1, 4)) : mem_lat;
                req_q.push_back(imem_addr);
            end
        end
    end

    // Reference: branch outcome straight from the instruction semantics.
    function automatic void ref_br(input logic v, input logic [3:0] op,
                                   input logic [31:0] pc, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [15:0] imm,
                                   input logic [25:0] tg, output logic t,
                                   output logic [31:0] target);
        int signed   s;
        longint      off;
        logic [31:0] seq;
        s   = rs;
        off = longint'($signed(imm));
        seq = pc + 32'd4;
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd9: t = 1'b1;
            4'd5, 4'd7:                   t = (s >= 0);
            4'd6, 4'd8:                   t = (s < 0);
            4'd10:                        t = (rs == rt);
            4'd11:                        t = (rs != rt);
            4'd12:                        t = (s <= 0);
            4'd13:                        t = (s > 0);
            default:                      t = 1'b0;
        endcase
        t = t && v;
        if (op == 4'd1)                      target = rs;
        else if (op == 4'd2 || op == 4'd3)   target = {seq[31:28], tg, 2'b00};
        else                                 target = 32'(longint'(seq) + off * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_accept(input string tag, output logic [31:0] pc, output logic [31:0] ins);
        int n = 0;
        while (!(if_valid === 1'b1 && if_ready === 1'b1) && n < 60) begin
            tick();
            n++;
        end
        check({tag, " accept"}, 32'(if_valid & if_ready), 32'd1);
        pc  = if_pc;
        ins = if_instr;
        tick();
    endtask

    task automatic wait_newreq(input string tag, input int base, output logic [31:0] addr);
        int n = 0;
        while (req_q.size() <= base && n < 60) begin
            tick();
            n++;
        end
        check({tag, " req seen"}, 32'(req_q.size() > base), 32'd1);
        addr = (req_q.size() > base) ? req_q[base] : 32'hDEAD_DEAD;
    endtask

    task automatic wait_req_cycle();
        int n = 0;
        while (imem_req !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("req cycle", 32'(imem_req), 32'd1);
    endtask

    task automatic do_branch(input string tag, input logic [3:0] op, input logic [31:0] pc,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input logic [25:0] tg,
                             output logic [31:0] rpc);
        logic        t;
        logic [31:0] tgt;
        logic [31:0] last;
        logic [31:0] nxt;
        int          base;
        ref_br(1'b1, op, pc, rs, rt, imm, tg, t, tgt);
        br_valid = 1'b1; br_op = op; br_pc = pc; br_rs = rs; br_rt = rt;
        br_imm = imm; br_tgt = tg;
        tick();
        br_valid = 1'b0;
        check({tag, " redirect"}, 32'(redirect), 32'(t));
        if (t) check({tag, " redirect_pc"}, redirect_pc, tgt);
        rpc  = redirect_pc;
        base = req_q.size();
        last = req_q[base - 1];
        tick();
        check({tag, " pulse end"}, 32'(redirect), 32'd0);
        wait_newreq(tag, base, nxt);
        check({tag, " next addr"}, nxt, t ? {tgt[31:2], 2'b00} : last + 32'd4);
    endtask

    initial begin
        logic [31:0] p, ins, hp, hi, rpc, nxt, exp_pc;
        logic        pt, t;
        logic [31:0] ptg, tg;
        int          base, n;

        rst_n = 1'b0; if_ready = 1'b0; br_valid = 1'b0; br_op = 4'd0;
        br_pc = '0; br_rs = '0; br_rt = '0; br_imm = '0; br_tgt = '0;
        imem_rdata = '0;
        repeat (2) tick();
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        check("rst if_valid", 32'(if_valid), 32'd0);
        check("rst if_instr", if_instr, 32'd0);
        check("rst if_pc", if_pc, 32'd0);
        check("rst redirect", 32'(redirect), 32'd0);
        check("rst redirect_pc", redirect_pc, 32'd0);

        // Sequential fetch, 1-cycle memory, decode always ready.
        rst_n = 1'b1; if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_accept("seq", p, ins);
            check("seq if_pc", p, RST_PC + 32'(4 * i));
            check("seq if_instr", ins, mem_word(RST_PC + 32'(4 * i)));
        end
        check("seq req0", req_q[0], 32'h3000);
        check("seq req1", req_q[1], 32'h3004);
        check("seq req2", req_q[2], 32'h3008);

        // Backpressure for five cycles in HOLD.
        if_ready = 1'b0;
        n = 0;
        while (if_valid !== 1'b1 && n < 20) begin tick(); n++; end
        check("bp valid", 32'(if_valid), 32'd1);
        hp = if_pc; hi = if_instr; base = req_q.size();
        check("bp pc", hp, 32'h300C);
        repeat (5) begin
            tick();
            check("bp hold valid", 32'(if_valid), 32'd1);
            check("bp hold pc", if_pc, hp);
            check("bp hold instr", if_instr, hi);
        end
        check("bp no req", 32'(req_q.size()), 32'(base));
        if_ready = 1'b1;
        tick();
        check("bp resume req", 32'(imem_req), 32'd1);
        check("bp resume addr", imem_addr, hp + 32'd4);

        do_branch("beq", 4'd10, 32'h3010, 32'd5, 32'd5, 16'hFFFC, 26'd0, rpc);
        check("beq target", rpc, 32'h3004);
        do_branch("bne", 4'd11, 32'h3020, 32'd7, 32'd7, 16'h0010, 26'd0, rpc);
        do_branch("bgtz", 4'd13, 32'h3020, 32'h8000_0000, 32'd0, 16'h0010, 26'd0, rpc);
        do_branch("blez", 4'd12, 32'h3100, 32'd0, 32'd0, 16'h0002, 26'd0, rpc);
        check("blez target", rpc, 32'h310C);

        // jr while a 3-cycle fetch is outstanding: stale word must vanish.
        mem_lat = 3;
        wait_req_cycle();
        tick();
        check("jr in wait", 32'(imem_req), 32'd0);
        br_valid = 1'b1; br_op = 4'd1; br_pc = 32'h3200; br_rs = 32'h0040_0000;
        tick();
        br_valid = 1'b0;
        check("jr redirect", 32'(redirect), 32'd1);
        check("jr redirect_pc", redirect_pc, 32'h0040_0000);
        base = req_q.size();
        n = 0;
        while (req_q.size() <= base && n < 20) begin
            check("jr flush valid", 32'(if_valid), 32'd0);
            tick();
            n++;
        end
        wait_newreq("jr", base, nxt);
        check("jr next addr", nxt, 32'h0040_0000);
        wait_accept("jr", p, ins);
        check("jr if_pc", p, 32'h0040_0000);
        check("jr if_instr", ins, mem_word(32'h0040_0000));

        mem_lat = 1;
        do_branch("j", 4'd2, 32'h3FFC, 32'd0, 32'd0, 16'd0, 26'h0000100, rpc);
        check("j target", rpc, 32'h0000_0400);

        // Asynchronous reset in the middle of a fetch.
        wait_req_cycle();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid rst imem_req", 32'(imem_req), 32'd0);
        check("mid rst imem_addr", imem_addr, 32'd0);
        check("mid rst if_valid", 32'(if_valid), 32'd0);
        check("mid rst if_instr", if_instr, 32'd0);
        check("mid rst if_pc", if_pc, 32'd0);
        check("mid rst redirect", 32'(redirect), 32'd0);
        check("mid rst redirect_pc", redirect_pc, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        base = req_q.size();
        wait_newreq("post rst", base, nxt);
        check("post rst addr", nxt, RST_PC);

        // Random traffic: random latency, backpressure and branches.
        rnd_lat = 1'b1;
        exp_pc  = RST_PC;
        pt = 1'b0; ptg = '0;
        for (int c = 0; c < 1500; c++) begin
            if (c > 0) begin
                check("rnd redirect", 32'(redirect), 32'(pt));
                if (pt) check("rnd redirect_pc", redirect_pc, ptg);
            end
            if_ready = ($urandom_range(0, 3) != 0);
            if (if_valid === 1'b1 && if_ready === 1'b1) begin
                check("rnd if_pc", if_pc, exp_pc);
                check("rnd if_instr", if_instr, mem_word({exp_pc[31:2], 2'b00}));
                exp_pc = exp_pc + 32'd4;
            end
            br_op  = 4'($urandom_range(0, 15));
            br_pc  = $urandom;
            case ($urandom_range(0, 4))
                0:       br_rs = 32'd0;
                1:       br_rs = 32'hFFFF_FFFF;
                2:       br_rs = 32'h8000_0000;
                3:       br_rs = 32'd1;
                default: br_rs = $urandom;
            endcase
            br_rt    = $urandom_range(0, 1) ? br_rs : $urandom;
            br_imm   = 16'($urandom);
            br_tgt   = 26'($urandom);
            br_valid = ($urandom_range(0, 5) == 0);
            ref_br(br_valid, br_op, br_pc, br_rs, br_rt, br_imm, br_tgt, t, tg);
            pt = t; ptg = tg;
            if (t) exp_pc = tg;
            tick();
        end
        br_valid = 1'b0;
        tick();
        check("rnd final redirect", 32'(redirect), 32'(pt));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
